// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// transaction owner encoding and default widths.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel
// Grant selection between IFU and LSU with an IFU starvation guard.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ifu_valid/lsu_valid requester valids
//   idle                arbiter is in IDLE and may grant this cycle
//   grant_ifu/grant_lsu one-hot (or zero) grant, combinational
module mem_arb_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic idle,
  output logic grant_ifu,
  output logic grant_lsu
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak_r;
  logic          starved_s;

  // IFU has waited through the maximum number of back-to-back LSU grants
  assign starved_s = (streak_r == LIMIT);

  // Priority select: LSU first unless IFU is starved
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (idle) begin
      if (lsu_valid && !(ifu_valid && starved_s)) begin
        grant_lsu = 1'b1;
      end else if (ifu_valid) begin
        grant_ifu = 1'b1;
      end else begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
      end
    end else begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
    end
  end

  // Count LSU grants that bypassed a waiting IFU; saturates at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_r <= {SW{1'b0}};
    end else if (grant_ifu) begin
      streak_r <= {SW{1'b0}};
    end else if (grant_lsu) begin
      if (!ifu_valid) begin
        streak_r <= {SW{1'b0}};
      end else if (!starved_s) begin
        streak_r <= streak_r + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single data-memory port between IFU (reads) and LSU
// (loads/stores). One transaction at a time: grant in IDLE, present the
// latched request in ISSUE, wait for the response in WAIT, route it back.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ifu_req_* / ifu_resp_* / ifu_rdata  IFU request/response channel
//   lsu_req_* / lsu_resp_* / lsu_rdata  LSU request/response channel
//   mem_req_* / mem_addr..mem_wstrb    request to memory (latched fields)
//   mem_resp_valid, mem_rdata          memory response
//   busy                               a transaction is in progress
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int SB = DATA_WIDTH / 8;

  state_t                  state_r;
  logic                    owner_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    wen_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [SB-1:0]           wstrb_r;

  logic idle_s;
  logic grant_ifu_s;
  logic grant_lsu_s;
  logic resp_s;

  // Reset is gated in so nothing handshakes during the reset cycle itself
  assign idle_s = (state_r == ST_IDLE) && !rst;

  mem_arb_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .clk       (clk),
    .rst       (rst),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .idle      (idle_s),
    .grant_ifu (grant_ifu_s),
    .grant_lsu (grant_lsu_s)
  );

  assign ifu_req_ready = grant_ifu_s;
  assign lsu_req_ready = grant_lsu_s;

  // Transaction sequencer: IDLE -> ISSUE -> WAIT -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  if (grant_ifu_s || grant_lsu_s) state_r <= ST_ISSUE;
        ST_ISSUE: if (mem_req_ready)              state_r <= ST_WAIT;
        ST_WAIT:  if (mem_resp_valid)             state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // Capture the winning request; IFU fetches are always plain reads
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= OWN_IFU;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wen_r   <= 1'b0;
      wdata_r <= {DATA_WIDTH{1'b0}};
      wstrb_r <= {SB{1'b0}};
    end else if (grant_lsu_s) begin
      owner_r <= OWN_LSU;
      addr_r  <= lsu_addr;
      wen_r   <= lsu_wen;
      wdata_r <= lsu_wdata;
      wstrb_r <= lsu_wstrb;
    end else if (grant_ifu_s) begin
      owner_r <= OWN_IFU;
      addr_r  <= ifu_addr;
      wen_r   <= 1'b0;
      wdata_r <= {DATA_WIDTH{1'b0}};
      wstrb_r <= {SB{1'b0}};
    end
  end

  assign mem_req_valid = (state_r == ST_ISSUE) && !rst;
  assign mem_addr      = addr_r;
  assign mem_wen       = wen_r;
  assign mem_wdata     = wdata_r;
  assign mem_wstrb     = wstrb_r;

  // Responses outside WAIT are strays and simply dropped
  assign resp_s = (state_r == ST_WAIT) && mem_resp_valid && !rst;

  assign ifu_resp_valid = resp_s && (owner_r == OWN_IFU);
  assign lsu_resp_valid = resp_s && (owner_r == OWN_LSU);

  // Store acks carry zero data; the non-owner always sees zero
  assign ifu_rdata = ifu_resp_valid ? mem_rdata : {DATA_WIDTH{1'b0}};
  assign lsu_rdata = (lsu_resp_valid && !wen_r) ? mem_rdata : {DATA_WIDTH{1'b0}};

  assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by randomized transactions checked against a
// transaction-level model of the arbitration and routing rules.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [3:0]    lsu_wstrb;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int streak_m = 0;

  // random-phase scratch
  bit            iv, lv, none_w, win_ifu;
  logic [AW-1:0] e_addr;
  logic          e_wen;
  logic [DW-1:0] e_wdata, e_data;
  logic [3:0]    e_wstrb;
  int            stall, lat, cyc;
  logic          got[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
  endtask

  // Model: which requester wins when at least one is valid (1 = IFU)
  function automatic bit model_pick(input bit i_v, input bit l_v);
    if (!l_v) return 1'b1;
    if (!i_v) return 1'b0;
    return (streak_m == LIM);
  endfunction

  // Model: streak bookkeeping after a grant
  function automatic void model_update(input bit w_ifu, input bit i_v);
    if (w_ifu || !i_v) streak_m = 0;
    else if (streak_m < LIM) streak_m = streak_m + 1;
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    next(); next();
    smp();
    chk("rst_ifu_ready", ifu_req_ready, 1'b0);
    chk("rst_lsu_ready", lsu_req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_mem_fields", {mem_addr, mem_wen, mem_wstrb}, 37'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    chk("rst_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
    next(); rst = 1'b0; streak_m = 0;

    // LSU load 0x8000_0010 -> 0xDEAD_BEEF
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b0;
    smp();
    chk("t1_lsu_ready", lsu_req_ready, 1'b1);
    chk("t1_ifu_ready", ifu_req_ready, 1'b0);
    next(); model_update(1'b0, 1'b0);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("t1_mem_valid", mem_req_valid, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h8000_0010);
    chk("t1_mem_wen", mem_wen, 1'b0);
    chk("t1_busy", busy, 1'b1);
    chk("t1_no_early_resp", lsu_resp_valid, 1'b0);
    next();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    smp();
    chk("t1_lsu_resp", lsu_resp_valid, 1'b1);
    chk("t1_lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
    chk("t1_ifu_resp", ifu_resp_valid, 1'b0);
    chk("t1_ifu_rdata", ifu_rdata, 32'h0);
    next(); mem_resp_valid = 1'b0;
    smp();
    chk("t1_resp_once", lsu_resp_valid, 1'b0);
    chk("t1_idle", busy, 1'b0);
    next();

    // Both valid: LSU first, IFU in the IDLE cycle after the response
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0020; lsu_wen = 1'b0;
    lsu_wdata = 32'hA5A5_A5A5; lsu_wstrb = 4'hF;
    smp();
    chk("t2_lsu_ready", lsu_req_ready, 1'b1);
    chk("t2_ifu_ready", ifu_req_ready, 1'b0);
    next(); model_update(1'b0, 1'b1);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("t2_issue_ifu_ready", ifu_req_ready, 1'b0);
    chk("t2_mem_addr", mem_addr, 32'h8000_0020);
    next();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0001;
    smp();
    chk("t2_lsu_resp", lsu_resp_valid, 1'b1);
    chk("t2_resp_cycle_ifu_ready", ifu_req_ready, 1'b0);
    next(); mem_resp_valid = 1'b0;
    smp();
    chk("t2_ifu_ready", ifu_req_ready, 1'b1);
    chk("t2_lsu_ready_idle", lsu_req_ready, 1'b0);
    next(); model_update(1'b1, 1'b1);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("t2_ifu_mem_addr", mem_addr, 32'h0000_1000);
    chk("t2_ifu_mem_wen", mem_wen, 1'b0);
    chk("t2_ifu_mem_wstrb", mem_wstrb, 4'h0);
    chk("t2_ifu_mem_wdata", mem_wdata, 32'h0);
    next();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    smp();
    chk("t2_ifu_resp", ifu_resp_valid, 1'b1);
    chk("t2_ifu_rdata", ifu_rdata, 32'h0BAD_F00D);
    chk("t2_lsu_resp_off", lsu_resp_valid, 1'b0);
    chk("t2_lsu_rdata_off", lsu_rdata, 32'h0);
    next(); mem_resp_valid = 1'b0;

    // Starvation guard: both always valid, memory always ready/responding
    clear_inputs(); rst = 1'b1; next(); rst = 1'b0; streak_m = 0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_2000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0040;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    cyc = 0;
    while (got.size() < 10 && cyc < 60) begin
      smp();
      chk("t3_exclusive", ifu_req_ready & lsu_req_ready, 1'b0);
      if (ifu_req_ready) got.push_back(1'b1);
      else if (lsu_req_ready) got.push_back(1'b0);
      next();
      cyc++;
    end
    chk("t3_grant_count", got.size(), 10);
    for (int i = 0; i < got.size(); i++) begin
      win_ifu = model_pick(1'b1, 1'b1);
      model_update(win_ifu, 1'b1);
      chk($sformatf("t3_order_%0d", i), got[i], win_ifu);
    end
    clear_inputs(); rst = 1'b1; next(); rst = 1'b0; streak_m = 0;

    // Store with a stalled memory port
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0100;
    lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b0011;
    smp();
    chk("t4_lsu_ready", lsu_req_ready, 1'b1);
    next(); model_update(1'b0, 1'b0);
    lsu_req_valid = 1'b0; lsu_addr = 32'hFFFF_FFFF; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("t4_stall_valid_%0d", k), mem_req_valid, 1'b1);
      chk($sformatf("t4_stall_fields_%0d", k), {mem_addr, mem_wen, mem_wstrb}, {32'h8000_0100, 1'b1, 4'b0011});
      chk($sformatf("t4_stall_wdata_%0d", k), mem_wdata, 32'h1234_5678);
      next();
    end
    mem_req_ready = 1'b1;
    smp();
    chk("t4_accept_valid", mem_req_valid, 1'b1);
    next();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    smp();
    chk("t4_ack", lsu_resp_valid, 1'b1);
    chk("t4_ack_rdata", lsu_rdata, 32'h0);
    next(); mem_resp_valid = 1'b0;

    // Reset while waiting, then a late response
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_3000;
    smp();
    chk("t5_ifu_ready", ifu_req_ready, 1'b1);
    next();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp(); next();
    mem_req_ready = 1'b0;
    smp();
    chk("t5_wait_busy", busy, 1'b1);
    next();
    rst = 1'b1;
    smp(); next();
    rst = 1'b0; streak_m = 0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0055;
    smp();
    chk("t5_late_ifu_resp", ifu_resp_valid, 1'b0);
    chk("t5_late_lsu_resp", lsu_resp_valid, 1'b0);
    chk("t5_late_busy", busy, 1'b0);
    chk("t5_late_rdata", ifu_rdata, 32'h0);
    next(); mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_4000;
    smp();
    chk("t5_new_ready", ifu_req_ready, 1'b1);
    next(); model_update(1'b1, 1'b1);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("t5_new_addr", mem_addr, 32'h0000_4000);
    next();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_600D;
    smp();
    chk("t5_new_resp", ifu_resp_valid, 1'b1);
    chk("t5_new_rdata", ifu_rdata, 32'h0000_600D);
    next(); mem_resp_valid = 1'b0;

    // Stray response in IDLE
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0077;
    smp();
    chk("t6_stray_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    chk("t6_stray_busy", busy, 1'b0);
    next(); mem_resp_valid = 1'b0;
    smp();
    chk("t6_after_busy", busy, 1'b0);
    chk("t6_after_mem_valid", mem_req_valid, 1'b0);
    next();

    // Randomized transactions against the model
    for (int it = 0; it < 60; it++) begin
      iv = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 3) != 0);
      ifu_addr = $urandom; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(0, 1));
      lsu_wdata = $urandom; lsu_wstrb = 4'($urandom_range(0, 15));
      ifu_req_valid = iv; lsu_req_valid = lv;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      none_w = !iv && !lv;
      win_ifu = none_w ? 1'b0 : model_pick(iv, lv);
      smp();
      chk("rnd_ifu_ready", ifu_req_ready, !none_w && win_ifu);
      chk("rnd_lsu_ready", lsu_req_ready, !none_w && !win_ifu);
      chk("rnd_stray", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      e_addr  = win_ifu ? ifu_addr : lsu_addr;
      e_wen   = win_ifu ? 1'b0 : lsu_wen;
      e_wdata = win_ifu ? 32'h0 : lsu_wdata;
      e_wstrb = win_ifu ? 4'h0 : lsu_wstrb;
      next();
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
      if (none_w) continue;
      model_update(win_ifu, iv);
      stall = $urandom_range(0, 2);
      for (int s = 0; s <= stall; s++) begin
        mem_req_ready = (s == stall);
        smp();
        chk("rnd_mem_valid", mem_req_valid, 1'b1);
        chk("rnd_mem_fields", {mem_addr, mem_wen, mem_wstrb}, {e_addr, e_wen, e_wstrb});
        chk("rnd_mem_wdata", mem_wdata, e_wdata);
        next();
      end
      mem_req_ready = 1'b0;
      lat = $urandom_range(0, 2);
      for (int l = 0; l < lat; l++) begin
        smp();
        chk("rnd_wait_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("rnd_wait_busy", busy, 1'b1);
        next();
      end
      e_data = $urandom;
      mem_resp_valid = 1'b1; mem_rdata = e_data;
      smp();
      chk("rnd_ifu_resp", ifu_resp_valid, win_ifu);
      chk("rnd_lsu_resp", lsu_resp_valid, !win_ifu);
      chk("rnd_ifu_rdata", ifu_rdata, win_ifu ? e_data : 32'h0);
      chk("rnd_lsu_rdata", lsu_rdata, (!win_ifu && !e_wen) ? e_data : 32'h0);
      next();
      mem_resp_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
